// File: rtl/pla_personality_loader.sv
// Serial loader for the PLA AND-plane personality memory.
// Takes one 2-bit cell symbol per accepted beat and assembles a row of COLS cells.
// Each complete row is written as a (care, value) pair in a one-cycle commit.
// cfg_valid is raised once every row has been written without an illegal symbol.
module pla_personality_loader #(
    parameter int ROWS = 4,
    parameter int COLS = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [1:0]                    in_sym,
    output logic                          wr_en,
    output logic [$clog2(ROWS+1)-1:0]     wr_addr,
    output logic [COLS-1:0]               wr_care,
    output logic [COLS-1:0]               wr_val,
    output logic                          cfg_valid,
    output logic                          err
);

    localparam int AW = $clog2(ROWS + 1);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    // Column 1 is the MSB of the row word; later columns shift right from here.
    localparam logic [COLS-1:0] COL1_BIT = COLS'(1) << (COLS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_COMMIT = 3'd2,
        S_DONE   = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [COLS-1:0] care_buf_q, care_buf_d;
    logic [COLS-1:0] val_buf_q, val_buf_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [COLS-1:0] wr_care_q, wr_care_d;
    logic [COLS-1:0] wr_val_q, wr_val_d;

    logic            accept;
    logic            sym_illegal;
    logic            sym_care;
    logic            sym_val;
    logic [COLS-1:0] cell_sel;
    logic [COLS-1:0] care_merged;
    logic [COLS-1:0] val_merged;

    // Symbol decode: '?' clears care, '1' is the only symbol with value 1.
    assign sym_illegal = (in_sym == 2'b11);
    assign sym_care    = (in_sym == 2'b00) || (in_sym == 2'b01);
    assign sym_val     = (in_sym == 2'b01);
    assign cell_sel    = COL1_BIT >> col_q;
    assign care_merged = care_buf_q | (sym_care ? cell_sel : '0);
    assign val_merged  = val_buf_q  | (sym_val  ? cell_sel : '0);

    assign in_ready  = (state_q == S_LOAD);
    assign cfg_valid = (state_q == S_DONE);
    assign err       = (state_q == S_ERR);
    // A start in the same cycle as a beat takes priority, so the beat stays pending.
    assign accept    = in_valid && in_ready && !start;

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_care = wr_care_q;
    assign wr_val  = wr_val_q;

    // Next-state: start restarts from any state; otherwise walk rows and columns.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        care_buf_d = care_buf_q;
        val_buf_d  = val_buf_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_care_d  = wr_care_q;
        wr_val_d   = wr_val_q;

        if (start) begin
            state_d    = S_LOAD;
            row_d      = '0;
            col_d      = '0;
            care_buf_d = '0;
            val_buf_d  = '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (accept) begin
                        if (sym_illegal) begin
                            state_d = S_ERR;
                        end else if (col_q == CW'(COLS - 1)) begin
                            // Row complete: the write strobe and data are registered
                            // so they appear together during the COMMIT cycle.
                            care_buf_d = care_merged;
                            val_buf_d  = val_merged;
                            wr_en_d    = 1'b1;
                            wr_addr_d  = row_q + AW'(1);
                            wr_care_d  = care_merged;
                            wr_val_d   = val_merged;
                            state_d    = S_COMMIT;
                        end else begin
                            care_buf_d = care_merged;
                            val_buf_d  = val_merged;
                            col_d      = col_q + CW'(1);
                        end
                    end
                end
                S_COMMIT: begin
                    if (row_q == AW'(ROWS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        row_d      = row_q + AW'(1);
                        col_d      = '0;
                        care_buf_d = '0;
                        val_buf_d  = '0;
                        state_d    = S_LOAD;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // State, counters, row buffer and write port registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            care_buf_q <= '0;
            val_buf_q  <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_care_q  <= '0;
            wr_val_q   <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            care_buf_q <= care_buf_d;
            val_buf_q  <= val_buf_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_care_q  <= wr_care_d;
            wr_val_q   <= wr_val_d;
        end
    end

endmodule

// File: tb/tb_pla_personality_loader.sv
// Bench for pla_personality_loader (ROWS=4, COLS=3): directed scenarios plus a
// randomized phase, all checked every cycle against a transaction-level model.
module tb_pla_personality_loader;

    localparam int ROWS = 4;
    localparam int COLS = 3;
    localparam int N    = ROWS * COLS;
    localparam int AW   = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_sym;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [COLS-1:0] wr_care;
    logic [COLS-1:0] wr_val;
    logic            cfg_valid;
    logic            err;

    always #5 clk = ~clk;

    pla_personality_loader #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_sym(in_sym), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_care(wr_care), .wr_val(wr_val), .cfg_valid(cfg_valid), .err(err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A load is a count of accepted legal cells; every COLS cells produce one write.
    bit              m_loaded = 1'b0;
    bit              m_err    = 1'b0;
    bit              m_wr     = 1'b0;
    int              m_n      = 0;
    int              m_since  = 0;
    int              m_syms[N];
    logic [AW-1:0]   m_addr = '0;
    logic [COLS-1:0] m_care = '0;
    logic [COLS-1:0] m_val  = '0;

    wire exp_ready = m_loaded && !m_err && !m_wr && (m_n < N);
    wire exp_cfg   = m_loaded && !m_err && !m_wr && (m_n == N);

    // Care/value word of row r, whose last cell is 'last' (not yet stored).
    function automatic logic [2*COLS-1:0] row_word(input int r, input int last);
        int c, v, s;
        c = 0; v = 0;
        for (int k = 0; k < COLS; k++) begin
            s = (k == COLS - 1) ? last : m_syms[r*COLS + k];
            c = c * 2 + ((s != 2) ? 1 : 0);
            v = v * 2 + ((s == 1) ? 1 : 0);
        end
        return {c[COLS-1:0], v[COLS-1:0]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_loaded <= 1'b0; m_err <= 1'b0; m_wr <= 1'b0; m_n <= 0; m_since <= 0;
            m_addr <= '0; m_care <= '0; m_val <= '0;
        end else begin
            m_since <= m_since + 1;
            m_wr    <= 1'b0;
            if (start) begin
                m_loaded <= 1'b1; m_err <= 1'b0; m_n <= 0; m_since <= 1;
            end else if (exp_ready && in_valid) begin
                if (in_sym == 2'd3) begin
                    m_err <= 1'b1;
                end else begin
                    m_syms[m_n] <= int'(in_sym);
                    m_n <= m_n + 1;
                    if ((m_n + 1) % COLS == 0) begin
                        m_wr   <= 1'b1;
                        m_addr <= AW'(m_n / COLS + 1);
                        {m_care, m_val} <= row_word(m_n / COLS, int'(in_sym));
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit              chk_on = 1'b0;
    int              cfg_at = -1;
    logic [8:0]      log_q[$];

    always @(negedge clk) begin
        if (chk_on) begin
            chk("in_ready",     32'(in_ready),  32'(exp_ready));
            chk("wr_en",        32'(wr_en),     32'(m_wr));
            chk("cfg_valid",    32'(cfg_valid), 32'(exp_cfg));
            chk("err",          32'(err),       32'(m_err));
            chk("wr_addr",      32'(wr_addr),   32'(m_addr));
            chk("wr_care",      32'(wr_care),   32'(m_care));
            chk("wr_val",       32'(wr_val),    32'(m_val));
            chk("commit_ready", 32'(wr_en & in_ready), 32'(0));
            if (wr_en && rst_n) log_q.push_back({wr_addr, wr_care, wr_val});
            if (start) cfg_at = -1;
            else if (cfg_valid && cfg_at < 0) cfg_at = m_since;
        end
    end

    // ---------------- stimulus helpers (all drive at posedge+1) ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    // Stream symbols with a proper handshake; optionally stop at the negedge
    // of the commit cycle writing stop_addr.
    task automatic send(input logic [1:0] q[$], input bit toggle, input int stop_addr);
        int idx = 0;
        int cyc = 0;
        bit fire;
        while (idx < q.size() && cyc < 400) begin
            in_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
            in_sym   = q[idx];
            @(negedge clk);
            fire = in_valid && in_ready;
            if (stop_addr != 0 && wr_en && int'(wr_addr) == stop_addr) begin
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (fire) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        if (idx < q.size()) chk("send_done", 32'(idx), 32'(q.size()));
    endtask

    task automatic wait_cfg(input string nm);
        for (int i = 0; i < 60; i++) begin
            if (cfg_valid) break;
            tick();
        end
        chk(nm, 32'(cfg_valid), 32'(1));
    endtask

    task automatic check_log(input string nm, input logic [8:0] exp[$]);
        chk({nm, "_count"}, 32'(log_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < log_q.size(); i++)
            chk($sformatf("%s_row%0d", nm, i), 32'(log_q[i]), 32'(exp[i]));
    endtask

    logic [1:0] pat_a[$] = '{2'd1, 2'd0, 2'd2,  2'd2, 2'd2, 2'd1,  2'd0, 2'd2, 2'd0,  2'd2, 2'd2, 2'd2};
    logic [1:0] pat_b[$] = '{2'd0, 2'd1, 2'd1,  2'd1, 2'd2, 2'd0,  2'd2, 2'd1, 2'd2,  2'd1, 2'd0, 2'd1};
    logic [1:0] pat_err[$] = '{2'd1, 2'd0, 2'd2,  2'd2, 2'd2, 2'd1,  2'd0, 2'd3};
    logic [1:0] pat_five[$] = '{2'd1, 2'd0, 2'd2,  2'd2, 2'd2};
    // {addr, care, val} literals
    logic [8:0] wr_a[$] = '{{3'd1, 3'b110, 3'b100}, {3'd2, 3'b001, 3'b001},
                            {3'd3, 3'b101, 3'b000}, {3'd4, 3'b000, 3'b000}};
    logic [8:0] wr_b[$] = '{{3'd1, 3'b111, 3'b011}, {3'd2, 3'b101, 3'b100},
                            {3'd3, 3'b010, 3'b010}, {3'd4, 3'b111, 3'b101}};
    logic [8:0] wr_a2[$] = '{{3'd1, 3'b110, 3'b100}, {3'd2, 3'b001, 3'b001}};
    logic [8:0] wr_a1[$] = '{{3'd1, 3'b110, 3'b100}};

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_sym = 2'd0;
        tick(); tick();
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        chk("rst_wr_en",    32'(wr_en),    32'(0));
        chk("rst_cfg",      32'(cfg_valid), 32'(0));
        chk("rst_err",      32'(err),      32'(0));
        chk("rst_wr_word",  32'({wr_addr, wr_care, wr_val}), 32'(0));
        rst_n = 1'b1; chk_on = 1'b1;
        tick();
        in_valid = 1'b1; in_sym = 2'd1;    // idle: symbol must stay pending
        tick(); tick();
        in_valid = 1'b0;

        // 1: held valid, literal writes and latency
        log_q.delete();
        pulse_start();
        send(pat_a, 1'b0, 0);
        wait_cfg("t1_cfg");
        tick();
        check_log("t1", wr_a);
        chk("t1_latency", 32'(cfg_at), 32'(17));

        // 6: start in DONE, then overwrite with pattern B
        pulse_start();
        chk("t6_cfg_drop", 32'(cfg_valid), 32'(0));
        chk("t6_ready",    32'(in_ready),  32'(1));
        log_q.delete();
        send(pat_b, 1'b0, 0);
        wait_cfg("t6_cfg");
        tick();
        check_log("t6", wr_b);

        // 2: toggled valid
        log_q.delete();
        pulse_start();
        send(pat_a, 1'b1, 0);
        wait_cfg("t2_cfg");
        tick();
        check_log("t2", wr_a);

        // 3: illegal symbol in row 3, then a clean reload
        log_q.delete();
        pulse_start();
        send(pat_err, 1'b0, 0);
        repeat (5) tick();
        chk("t3_err", 32'(err),       32'(1));
        chk("t3_cfg", 32'(cfg_valid), 32'(0));
        check_log("t3", wr_a2);
        pulse_start();
        chk("t3_err_clr", 32'(err), 32'(0));
        send(pat_a, 1'b0, 0);
        wait_cfg("t3_cfg_reload");
        chk("t3_err_final", 32'(err), 32'(0));
        tick();

        // 4: restart after 5 symbols; start collides with a valid beat
        log_q.delete();
        pulse_start();
        send(pat_five, 1'b0, 0);
        tick();
        check_log("t4_pre", wr_a1);
        log_q.delete();
        in_sym = pat_b[0]; in_valid = 1'b1;
        pulse_start();
        send(pat_b, 1'b0, 0);
        wait_cfg("t4_cfg");
        tick();
        check_log("t4", wr_b);

        // 5: async reset during the row-2 commit
        pulse_start();
        send(pat_a, 1'b0, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_wr_en",  32'(wr_en),     32'(0));
        chk("t5_ready",  32'(in_ready),  32'(0));
        chk("t5_cfg",    32'(cfg_valid), 32'(0));
        chk("t5_err",    32'(err),       32'(0));
        chk("t5_word",   32'({wr_addr, wr_care, wr_val}), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_valid = 1'b1; in_sym = 2'd1;
        for (int i = 0; i < 3; i++) begin
            chk("t5_idle_ready", 32'(in_ready), 32'(0));
            tick();
        end
        in_valid = 1'b0;

        // randomized phase
        for (int i = 0; i < 4000; i++) begin
            start    = ($urandom_range(0, 49) == 0);
            in_valid = ($urandom_range(0, 2) != 0);
            in_sym   = ($urandom_range(0, 29) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0; tick(); rst_n = 1'b1;
            end else begin
                tick();
            end
        end
        start = 1'b0; in_valid = 1'b0;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
